// File: rtl/core.sv
// rtl/core.sv - pipeline stage-register types shared across the core
// MEM_MISALIGN_CHECK_EN adds the misaligned flag to mem_wb_t.
package core;

  typedef logic bool_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       has_rd;
    logic [4:0] rd_num;
  } de_inst_t;

  typedef struct packed {
    logic        valid;
    de_inst_t    de_inst;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] rs2_value;
  } reg_fwd_t;

  typedef struct packed {
    logic        valid;
    de_inst_t    de_inst;
    logic [31:0] mem_result;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif
  } mem_wb_t;

endpackage

// File: rtl/rv32i.sv
// rtl/rv32i.sv - RV32I opcode and load/store funct3 encodings
package rv32i;

  localparam logic [6:0] opcode_load  = 7'b0000011;
  localparam logic [6:0] opcode_store = 7'b0100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response port
interface mem_stage_if #(
  parameter int ADDR_W = 32
);

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [3:0]        dmem_req_be;
  logic [31:0]       dmem_req_wdata;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rsp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_we,
    output dmem_req_addr,
    output dmem_req_be,
    output dmem_req_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_we,
    input  dmem_req_addr,
    input  dmem_req_be,
    input  dmem_req_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rsp_rdata
  );

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane placement and load extraction/extension
module mem_align
  import rv32i::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2_value,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    be    = 4'b1111;
    wdata = rs2_value;
    if (is_store) begin
      case (funct3)
        SB: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2_value[7:0]}};
        end
        SH: begin
          be    = 4'b0011 << {off[1], 1'b0};
          wdata = {2{rs2_value[15:0]}};
        end
        SW: begin
          be    = 4'b1111;
          wdata = rs2_value;
        end
        default: begin
          be    = 4'b1111;
          wdata = rs2_value;
        end
      endcase
    end
  end

  // Halfword selection uses off[1] only, so a stray off[0] aligns down.
  always_comb begin
    rd_byte   = rdata[{off, 3'b000} +: 8];
    rd_half   = rdata[{off[1], 4'b0000} +: 16];
    load_data = rdata;
    case (funct3)
      LB:      load_data = {{24{rd_byte[7]}}, rd_byte};
      LBU:     load_data = {24'h0, rd_byte};
      LH:      load_data = {{16{rd_half[15]}}, rd_half};
      LHU:     load_data = {16'h0, rd_half};
      LW:      load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: dmem access FSM and mem_wb register
// MEM_MISALIGN_CHECK_EN completes misaligned halfword/word accesses without a request.
module mem_stage
  import core::*;
  import rv32i::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ex_mem_t            ex_mem,
  input  reg_fwd_t           mem_reg_fwd,
  output mem_wb_t            mem_wb,
  output bool_t              mem_stall,
  mem_stage_if.master        dmem
);

  mem_state_t  state_q, state_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misalign;
  logic        req_valid;
  logic        complete;
  logic [1:0]  off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  always_comb begin
    off      = ex_mem.ex_result[1:0];
    is_load  = ex_mem.valid && (ex_mem.de_inst.opcode == opcode_load);
    is_store = ex_mem.valid && (ex_mem.de_inst.opcode == opcode_store);
    is_mem   = is_load || is_store;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign = is_mem &&
               (((ex_mem.de_inst.funct3[1:0] == 2'b01) && off[0]) ||
                ((ex_mem.de_inst.funct3[1:0] == 2'b10) && (off != 2'b00)));
`else
    misalign = 1'b0;
`endif
  end

  mem_align u_align (
    .is_store  (is_store),
    .funct3    (ex_mem.de_inst.funct3),
    .off       (off),
    .rs2_value (mem_reg_fwd.rs2_value),
    .rdata     (dmem.dmem_rsp_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (load_data)
  );

  // Responses are only meaningful in S_WAIT; in S_IDLE they are ignored.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_valid = is_mem && !misalign;
        if (ex_mem.valid && (!is_mem || misalign)) begin
          complete = 1'b1;
        end else if (req_valid && dmem.dmem_req_ready) begin
          if (is_store) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem.dmem_rsp_valid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_stall = is_mem && !complete;
  end

  assign dmem.dmem_req_valid = req_valid;
  assign dmem.dmem_req_we    = is_store;
  assign dmem.dmem_req_addr  = {ex_mem.ex_result[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_req_be    = lane_be;
  assign dmem.dmem_req_wdata = lane_wdata;

  always_comb begin
    mem_wb_d       = mem_wb_q;
    mem_wb_d.valid = complete;
    if (complete) begin
      mem_wb_d.de_inst    = ex_mem.de_inst;
      mem_wb_d.mem_result = (state_q == S_WAIT) ? load_data : ex_mem.ex_result;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_wb_d.misaligned = misalign;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign mem_wb = mem_wb_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage RV32I pipeline. Consumes the `ex_mem` pipeline register together with the hazard unit's `mem_reg_fwd` operands. Performs loads and stores over a valid/ready data-memory port, aligns and extends load data, and registers the `mem_wb` stage register. Asserts `mem_stall` to hold the upstream stages while a memory access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 32: data-memory byte-address width.

Ports:
- `clk` in 1: pipeline clock; one clock domain, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_mem` in `core::ex_mem_t`: execute-stage register. Fields used: `valid`, `de_inst.opcode`, `de_inst.funct3`, `de_inst.has_rd`, `de_inst.rd_num`, `ex_result` (ALU result / effective address).
- `mem_reg_fwd` in `core::reg_fwd_t`: forwarded operands; `rs2_value` is the store data.
- `mem_wb` out `core::mem_wb_t`: registered memory-stage output.
- `mem_stall` out `bool_t`: upstream stages must hold `ex_mem` unchanged while this is 1.
- `dmem_req_valid` out 1: request valid.
- `dmem_req_ready` in 1: request accepted on a cycle where valid and ready are both 1.
- `dmem_req_we` out 1: 1 = store.
- `dmem_req_addr` out `ADDR_W`: word-aligned address, i.e. `ex_result` with bits [1:0] cleared.
- `dmem_req_be` out 4: byte enables.
- `dmem_req_wdata` out 32: lane-positioned store data.
- `dmem_rsp_valid` in 1: load data valid, at the earliest one cycle after acceptance.
- `dmem_rsp_rdata` in 32: raw word read.

## Operation
- Op class is decoded from `ex_mem.valid` and `opcode`: `opcode_load`, `opcode_store`, or other (non-memory).
- FSM states, encoded as `core::mem_state_t`:
  - S_IDLE, from S_IDLE:
    - Valid memory op: drive `dmem_req_valid`=1 combinationally from `ex_mem`.
    - Store accepted (valid and ready): completes.
    - Load accepted: go to S_WAIT.
    - Not accepted: stay in S_IDLE and keep the request stable.
  - S_WAIT: `dmem_req_valid`=0. On `dmem_rsp_valid`=1 the load completes and the FSM returns to S_IDLE.
- `dmem_rsp_valid` is ignored in S_IDLE.
- `mem_stall` = `ex_mem.valid` and memory op and not completing this cycle. It is combinational.
- Completion cycle: at the next edge, `mem_wb` loads with `valid`=1, `de_inst` copied from `ex_mem`, and `mem_result` set as follows:
  - Non-memory op: `ex_result`.
  - Store: `ex_result`. `has_rd` is 0, so the value is unused.
  - Load: extracted data.
- Any cycle without completion: `mem_wb.valid`=0 (bubble). The other `mem_wb` fields hold their previous values.
- Load extraction, with `off` = `ex_result[1:0]`:
  - LB/LBU: byte `off`, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword `off[1]`, sign- or zero-extended.
  - LW: the full word.
- Store lanes:
  - SB: `be` = `4'b0001<<off`, `wdata` = byte replicated ×4.
  - SH: `be` = `4'b0011<<(off[1]*2)`, `wdata` = halfword replicated ×2.
  - SW: `be` = `4'b1111`, `wdata` = `rs2_value`.
- Loads drive `be`=`4'b1111`. `be`/`wdata` are don't-care whenever `dmem_req_valid`=0.

## Timing
- Reset values: FSM=S_IDLE, `mem_wb` all-zero (`valid`=0). Combinational outputs follow from S_IDLE; with `ex_mem.valid`=0 they are `mem_stall`=0 and `dmem_req_valid`=0.
- Latency to `mem_wb.valid`:
  - Non-memory op: 1 cycle.
  - Store with ready high: 1 cycle.
  - Load with ready high and response on the next cycle: 2 cycles, including 1 stall cycle.
- Every additional not-ready cycle or response wait adds one stall cycle.
- At most one outstanding access; no request is issued while in S_WAIT.
- Back-to-back memory ops: the next `ex_mem` arrives on the edge after completion and may issue in that same cycle.
- Reset mid-access: asynchronous return to S_IDLE and `mem_wb.valid`=0. The data memory must share `rst_n`, so no stale response arrives.
- `ex_mem.valid`=0: no request, no stall, bubble out.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - A halfword with `off[0]`=1, or a word with `off`≠0, issues no request and completes in 1 cycle.
  - It produces `mem_wb.valid`=1 with `mem_wb.misaligned`=1 and `mem_result`=`ex_result`.
- Macro undefined:
  - The `misaligned` field is absent from `mem_wb_t`.
  - Offending low address bits are ignored: a halfword uses `off[1]`, a word is aligned down. The access is issued normally.

## Structure
- `core` package gets:
  - `mem_state_t` enum (S_IDLE, S_WAIT).
  - The `misaligned` field in `mem_wb_t`, under the same macro.
- `rv32i` package gets the load/store funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Sub-module `mem_align`, purely combinational:
  - Store path: `funct3`, `off`, `rs2_value` → `be`, `wdata`.
  - Load path: `funct3`, `off`, `rdata` → extended result.

## Test plan
- Non-memory op: ADD with `ex_result`=0x12 → `mem_wb.valid`=1 next cycle, `mem_result`=0x12, `mem_stall` never 1.
- SB at 0x1003, `rs2`=0xAB, ready high → `be`=4'b1000, `wdata`=0xABABABAB, `addr`=0x1000, 1-cycle completion.
- LH at 0x2002, ready delayed 2 cycles, response 0x8001_7FFF 3 cycles after acceptance:
  - `mem_stall` high 5 cycles.
  - `mem_result`=0xFFFF_8001; LHU gives 0x0000_8001.
- LB at 0x0 followed by LBU at 0x1, zero wait → two `mem_wb.valid` pulses, with the second load issuing in the completion edge's next cycle.
- `rst_n` low while in S_WAIT → FSM idle and `mem_wb.valid`=0 immediately (asynchronously); no completion after release.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x3002 → no `dmem_req_valid`, `mem_wb.misaligned`=1 after 1 cycle.
